mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 30 +++
 rtl/mem_responder_if.sv | 26 ++
 rtl/mem_responder_wmask_merge.sv | 20 ++
 rtl/mem_responder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder: FSM states, default
// geometry and bus widths, plus the address window check.
package mem_responder_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned WORD_W = ADDR_W - 2;
  localparam int unsigned CNT_W  = 4;

  localparam logic [ADDR_W-1:0] DEF_BASE    = 32'h8000_0000;
  localparam int unsigned       DEF_DEPTH   = 1024;
  localparam int unsigned       DEF_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Word-granular compare so BASE+4*DEPTH never aliases back onto word 0.
  function automatic logic addr_in_range(input logic [WORD_W-1:0] word,
                                         input logic [WORD_W-1:0] base_word,
                                         input int unsigned       depth);
    logic [WORD_W-1:0] off;
    off = word - base_word;
    return (word >= base_word) && ({2'b00, off} < depth);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator (master) and the memory responder (slave).
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_responder_wmask_merge.sv
// Byte-lane merge: each enabled lane takes the new data, others keep the old word.
module wmask_merge
  import mem_responder_pkg::*;
(
  input  logic [DATA_W-1:0] old_i,
  input  logic [DATA_W-1:0] new_i,
  input  logic [MASK_W-1:0] mask_i,
  output logic [DATA_W-1:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int unsigned b = 0; b < MASK_W; b++) begin
      if (mask_i[b]) begin
        merged_o[8*b +: 8] = new_i[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accepts one request, waits LATENCY
// cycles, performs the masked write or read, and holds the response until taken.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE    = DEF_BASE,
  parameter int unsigned       DEPTH   = DEF_DEPTH,
  parameter int unsigned       LATENCY = DEF_LATENCY
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int unsigned      IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LOAD_CNT = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic              wen_q;
  logic              err_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [MASK_W-1:0] wmask_q;

  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rerr_q, rerr_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              mem_we;
  logic [WORD_W-1:0] req_word;
  logic              cur_err;
  logic [IDX_W-1:0]  cur_idx;

  logic              sel_wen;
  logic              sel_err;
  logic [IDX_W-1:0]  sel_idx;
  logic [DATA_W-1:0] sel_wdata;
  logic [MASK_W-1:0] sel_wmask;
  logic [DATA_W-1:0] merged;

  assign req_word = bus.req_addr[ADDR_W-1:2];
  assign cur_err  = !addr_in_range(req_word, BASE[ADDR_W-1:2], DEPTH);
  assign cur_idx  = IDX_W'(req_word - BASE[ADDR_W-1:2]);
  assign accept   = bus.req_valid && (state_q == IDLE);

  // With LATENCY=0 the access happens on the accept edge itself, before the
  // request fields are latched, so the live bus fields are used from IDLE.
  always_comb begin
    if (state_q == IDLE) begin
      sel_wen   = bus.req_wen;
      sel_err   = cur_err;
      sel_idx   = cur_idx;
      sel_wdata = bus.req_wdata;
      sel_wmask = bus.req_wmask;
    end else begin
      sel_wen   = wen_q;
      sel_err   = err_q;
      sel_idx   = idx_q;
      sel_wdata = wdata_q;
      sel_wmask = wmask_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = LOAD_CNT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_q != RESP) && (state_d == RESP);

  always_comb begin
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    if (enter_resp) begin
      rerr_d  = sel_err;
      rdata_d = (sel_wen || sel_err) ? '0 : mem_q[sel_idx];
    end
  end

  wmask_merge u_merge (
    .old_i    (mem_q[sel_idx]),
    .new_i    (sel_wdata),
    .mask_i   (sel_wmask),
    .merged_o (merged)
  );

  // Storage sits outside the reset domain; the rst term drops any commit
  // that would coincide with an asserted reset.
  assign mem_we = enter_resp && sel_wen && !sel_err && rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[sel_idx] <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
      if (accept) begin
        wen_q   <= bus.req_wen;
        err_q   <= cur_err;
        idx_q   <= cur_idx;
        wdata_q <= bus.req_wdata;
        wmask_q <= bus.req_wmask;
      end
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = rerr_q;

endmodule
